// File: rtl/dff_pipe_bank.sv
// DEPTH-stage x WIDTH-bit DFF pipeline with per-stage valid, flush and registered occupancy.
// Data and valid shift together on each effective enable; the occupancy register tracks the next-state valid count.

module dff_pipe_stage #(
    parameter int   WIDTH  = 8,
    parameter logic SR_B   = 1'b0,
    parameter logic INIT_B = 1'b0
) (
    input  logic             clk,
    input  logic             sr,
    input  logic             en,
    input  logic             flush,
    input  logic [WIDTH-1:0] d,
    input  logic             d_valid,
    output logic [WIDTH-1:0] q,
    output logic             q_valid
);
    // Declaration initialisers give the power-up value before any reset.
    logic [WIDTH-1:0] r_q = {WIDTH{INIT_B}};
    logic             r_v = 1'b0;

    always_ff @(posedge clk) begin
        if (!sr) begin
            r_q <= {WIDTH{SR_B}};
            r_v <= 1'b0;
        end else begin
            if (en)
                r_q <= d;
            if (flush)
                r_v <= 1'b0;
            else if (en)
                r_v <= d_valid;
        end
    end

    assign q       = r_q;
    assign q_valid = r_v;
endmodule

module dff_pipe_bank #(
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 4,
    parameter int EN_INV = 0,
    parameter int SR_VAL = 0,
    parameter int INIT   = 0
) (
    input  logic                       clk,
    input  logic                       sr,
    input  logic                       en,
    input  logic                       flush,
    input  logic [WIDTH-1:0]           d,
    input  logic                       d_valid,
    output logic [WIDTH-1:0]           q,
    output logic                       q_valid,
    output logic [WIDTH*DEPTH-1:0]     stage_q,
    output logic [$clog2(DEPTH+1)-1:0] occupancy
);
    localparam int   OCC_W    = $clog2(DEPTH+1);
    localparam logic EN_INV_B = (EN_INV != 0);
    localparam logic SR_B     = (SR_VAL != 0);
    localparam logic INIT_B   = (INIT != 0);

    logic                        w_en;
    logic [DEPTH:0][WIDTH-1:0]   w_d;
    logic [DEPTH:0]              w_v;
    logic [DEPTH-1:0]            w_vld_nxt;
    logic [OCC_W-1:0]            w_occ_nxt;
    logic [OCC_W-1:0]            r_occ = '0;

    assign w_en   = en ^ EN_INV_B;
    assign w_d[0] = d;
    assign w_v[0] = d_valid;

    // Index k+1 of the chain is the output of stage k.
    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        dff_pipe_stage #(
            .WIDTH  (WIDTH),
            .SR_B   (SR_B),
            .INIT_B (INIT_B)
        ) u_stage (
            .clk     (clk),
            .sr      (sr),
            .en      (w_en),
            .flush   (flush),
            .d       (w_d[k]),
            .d_valid (w_v[k]),
            .q       (w_d[k+1]),
            .q_valid (w_v[k+1])
        );
        assign stage_q[k*WIDTH +: WIDTH] = w_d[k+1];
    end

    // Mirror the valid-bit next state so the count lands in the same cycle as the valids.
    always_comb begin
        w_vld_nxt = w_v[DEPTH:1];
        if (flush)
            w_vld_nxt = '0;
        else if (w_en)
            w_vld_nxt = w_v[DEPTH-1:0];
        w_occ_nxt = '0;
        for (int k = 0; k < DEPTH; k++)
            w_occ_nxt = w_occ_nxt + OCC_W'(w_vld_nxt[k]);
    end

    always_ff @(posedge clk) begin
        if (!sr)
            r_occ <= '0;
        else
            r_occ <= w_occ_nxt;
    end

    assign q         = w_d[DEPTH];
    assign q_valid   = w_v[DEPTH];
    assign occupancy = r_occ;
endmodule
